// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch unit.
package imem_pkg;

    typedef enum logic {
        IMEM_LOAD,
        IMEM_RUN
    } imem_state_e;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

    // Byte-addressed PCs drop the two offset bits to form the word index.
    function automatic logic [31:0] word_index(input logic [31:0] pc, input logic byte_addr);
        return byte_addr ? (pc >> 2) : pc;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port instruction RAM: synchronous write, registered synchronous read.
module imem_array #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_W    = 10,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // rdata only moves on a read, so it holds the last fetched word otherwise.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with load/run modes, fetch handshake, fault sidebands and halt/flush.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int unsigned          DATA_W    = 32,
    parameter int unsigned          DEPTH     = 1024,
    parameter int unsigned          ADDR_W    = 10,
    parameter bit                   BYTE_ADDR = 1'b0,
    parameter logic [DATA_W-1:0]    NOP_WORD  = DATA_W'(IMEM_NOP),
    parameter string                INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              run,
    input  logic              halt,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_rdy,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    input  logic              instr_ready,
    output logic              fault_oob,
    output logic              fault_misalign,
    output logic              prog_reject,
    output logic              running
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    imem_state_e       state_q, state_d;
    logic              instr_valid_q;
    logic              nop_sel_q;
    logic              fault_oob_q;
    logic              fault_misalign_q;
    logic              prog_reject_q;

    logic [31:0]       pc_index;
    logic              pc_oob;
    logic              pc_misalign;
    logic              accept;
    logic              load_we;
    logic              ram_en;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IMEM_LOAD: if (run)  state_d = IMEM_RUN;
            IMEM_RUN:  if (halt) state_d = IMEM_LOAD;
        endcase
    end

    assign running     = (state_q == IMEM_RUN);
    assign fetch_rdy   = running && !halt && (!instr_valid_q || instr_ready);
    assign accept      = fetch_req && fetch_rdy;

    assign pc_index    = word_index(32'(fetch_pc), BYTE_ADDR);
    assign pc_oob      = (pc_index >= DEPTH);
    assign pc_misalign = BYTE_ADDR && (fetch_pc[1:0] != 2'b00);
    assign load_we     = !running && prog_we && (32'(prog_addr) < DEPTH);

    // Out-of-range fetches never touch the array; the output mux supplies the NOP.
    always_comb begin
        ram_en   = load_we || (accept && !pc_oob);
        ram_addr = load_we ? prog_addr[IDX_W-1:0] : pc_index[IDX_W-1:0];
    end

    imem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (load_we),
        .addr  (ram_addr),
        .wdata (prog_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IMEM_LOAD;
            instr_valid_q    <= 1'b0;
            nop_sel_q        <= 1'b1;
            fault_oob_q      <= 1'b0;
            fault_misalign_q <= 1'b0;
            prog_reject_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prog_reject_q <= running && prog_we;
            if (running && halt) begin
                instr_valid_q <= 1'b0;
            end else if (accept) begin
                instr_valid_q    <= 1'b1;
                nop_sel_q        <= pc_oob || pc_misalign;
                fault_oob_q      <= pc_oob;
                fault_misalign_q <= pc_misalign;
            end else if (instr_ready) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign instr_valid    = instr_valid_q;
    assign instr          = nop_sel_q ? NOP_WORD : ram_rdata;
    assign fault_oob      = fault_oob_q;
    assign fault_misalign = fault_misalign_q;
    assign prog_reject    = prog_reject_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench: word-addressed DEPTH=1000 unit plus a byte-addressed DEPTH=16 unit.
module tb_imem_fetch_unit;

    localparam int unsigned DEPTH = 1000;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] PROG [0:8] = '{
        32'h8C08_0000, 32'h8C09_0004, 32'h0109_5020, 32'h0109_5822, 32'hAC0A_0008,
        32'hAC0B_000C, 32'h014B_6020, 32'h014B_6822, 32'hAC0C_0010
    };

    typedef struct packed {
        logic [31:0] instr;
        logic        oob;
        logic        mis;
    } beat_t;

    beat_t       sb [$];
    beat_t       e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [0:DEPTH-1];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prog_we, run, halt, fetch_req, instr_ready;
    logic [9:0]  prog_addr, fetch_pc;
    logic [31:0] prog_data, instr;
    logic        fetch_rdy, instr_valid, fault_oob, fault_misalign, prog_reject, running;

    logic        b_prog_we, b_run, b_halt, b_fetch_req, b_instr_ready;
    logic [7:0]  b_prog_addr, b_fetch_pc;
    logic [31:0] b_prog_data, b_instr;
    logic        b_fetch_rdy, b_instr_valid, b_fault_oob, b_fault_misalign, b_prog_reject;
    logic        b_running;

    always #5 clk = ~clk;

    imem_fetch_unit #(
        .DATA_W (32), .DEPTH (DEPTH), .ADDR_W (10), .BYTE_ADDR (1'b0), .NOP_WORD (NOP)
    ) dut (
        .clk (clk), .rst_n (rst_n), .prog_we (prog_we), .prog_addr (prog_addr),
        .prog_data (prog_data), .run (run), .halt (halt), .fetch_req (fetch_req),
        .fetch_pc (fetch_pc), .fetch_rdy (fetch_rdy), .instr_valid (instr_valid),
        .instr (instr), .instr_ready (instr_ready), .fault_oob (fault_oob),
        .fault_misalign (fault_misalign), .prog_reject (prog_reject), .running (running)
    );

    imem_fetch_unit #(
        .DATA_W (32), .DEPTH (16), .ADDR_W (8), .BYTE_ADDR (1'b1), .NOP_WORD (NOP)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .prog_we (b_prog_we), .prog_addr (b_prog_addr),
        .prog_data (b_prog_data), .run (b_run), .halt (b_halt), .fetch_req (b_fetch_req),
        .fetch_pc (b_fetch_pc), .fetch_rdy (b_fetch_rdy), .instr_valid (b_instr_valid),
        .instr (b_instr), .instr_ready (b_instr_ready), .fault_oob (b_fault_oob),
        .fault_misalign (b_fault_misalign), .prog_reject (b_prog_reject),
        .running (b_running)
    );

    function automatic beat_t exp_for(input int pc);
        if (pc >= int'(DEPTH)) return {NOP, 1'b1, 1'b0};
        return {model[pc], 1'b0, 1'b0};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pop_exp();
        if (sb.size() > 0) e = sb.pop_front();
        else e = '1;
    endtask

    task automatic prog_word(input int addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = 10'(addr);
        prog_data = data;
        if (addr < int'(DEPTH)) model[addr] = data;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        prog_we = 0; run = 0; halt = 0; fetch_req = 0; instr_ready = 1;
        prog_addr = '0; prog_data = '0; fetch_pc = '0;
        b_prog_we = 0; b_run = 0; b_halt = 0; b_fetch_req = 0; b_instr_ready = 1;
        b_prog_addr = '0; b_prog_data = '0; b_fetch_pc = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({running, instr_valid, fetch_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got run=%b v=%b rdy=%b, want 0 0 0",
                     running, instr_valid, fetch_rdy);
        end
        checks++;
        if (instr !== NOP) begin
            errors++;
            $display("FAIL reset_instr: got %h, want %h", instr, NOP);
        end
        checks++;
        if ({fault_oob, fault_misalign, prog_reject, b_running, b_prog_reject} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got oob=%b mis=%b rej=%b b_run=%b b_rej=%b, want 0",
                     fault_oob, fault_misalign, prog_reject, b_running, b_prog_reject);
        end
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 9; i++) prog_word(i, PROG[i]);
        prog_word(999, 32'h2402_03E7);
        prog_word(1000, 32'hFFFF_FFFF);
        pulse_run();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL stream_running: got %b, want 1", running);
        end
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                pop_exp();
                checks++;
                if ({instr_valid, instr, fault_oob, fault_misalign} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got v=%b %h oob=%b mis=%b, want v=1 %h %b %b",
                             k - 1, instr_valid, instr, fault_oob, fault_misalign,
                             e.instr, e.oob, e.mis);
                end
            end
            if (k < 9) begin
                fetch_req = 1'b1;
                fetch_pc  = 10'(k);
                #1;
                checks++;
                if (fetch_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_rdy%0d: got %b, want 1", k, fetch_rdy);
                end
                sb.push_back(exp_for(k));
            end else begin
                fetch_req = 1'b0;
            end
            tick();
        end
        checks++;
        if ({instr_valid, instr} !== {1'b0, PROG[8]}) begin
            errors++;
            $display("FAIL stream_drain: got v=%b %h, want v=0 %h", instr_valid, instr, PROG[8]);
        end
    endtask

    task automatic test_backpressure();
        beat_t held;
        fetch_req = 1'b1;
        fetch_pc  = 10'd5;
        sb.push_back(exp_for(5));
        tick();
        pop_exp();
        held = e;
        instr_ready = 1'b0;
        fetch_pc    = 10'd6;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (fetch_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_rdy%0d: got %b, want 0", c, fetch_rdy);
            end
            tick();
            checks++;
            if ({instr_valid, instr, fault_oob, fault_misalign} !== {1'b1, held}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b %h, want v=1 %h", c, instr_valid, instr,
                         held.instr);
            end
        end
        instr_ready = 1'b1;
        #1;
        checks++;
        if (fetch_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_rdy: got %b, want 1", fetch_rdy);
        end
        sb.push_back(exp_for(6));
        tick();
        fetch_req = 1'b0;
        pop_exp();
        checks++;
        if ({instr_valid, instr, fault_oob, fault_misalign} !== {1'b1, e}) begin
            errors++;
            $display("FAIL stall_next: got v=%b %h, want v=1 %h", instr_valid, instr, e.instr);
        end
        tick();
    endtask

    task automatic test_faults();
        int pcs [4] = '{999, 1000, 1023, 4};
        for (int i = 0; i <= 4; i++) begin
            if (i > 0) begin
                pop_exp();
                checks++;
                if ({instr_valid, instr, fault_oob, fault_misalign} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL fault_pc%0d: got v=%b %h oob=%b mis=%b, want v=1 %h %b %b",
                             pcs[i-1], instr_valid, instr, fault_oob, fault_misalign,
                             e.instr, e.oob, e.mis);
                end
            end
            if (i < 4) begin
                fetch_req = 1'b1;
                fetch_pc  = 10'(pcs[i]);
                sb.push_back(exp_for(pcs[i]));
            end else begin
                fetch_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_prog_reject();
        prog_we   = 1'b1;
        prog_addr = 10'd3;
        prog_data = 32'hDEAD_BEEF;
        tick();
        prog_we = 1'b0;
        checks++;
        if (prog_reject !== 1'b1) begin
            errors++;
            $display("FAIL reject_pulse: got %b, want 1", prog_reject);
        end
        tick();
        checks++;
        if (prog_reject !== 1'b0) begin
            errors++;
            $display("FAIL reject_clear: got %b, want 0", prog_reject);
        end
        fetch_req = 1'b1;
        fetch_pc  = 10'd3;
        sb.push_back(exp_for(3));
        tick();
        fetch_req = 1'b0;
        pop_exp();
        checks++;
        if ({instr_valid, instr} !== {1'b1, e.instr}) begin
            errors++;
            $display("FAIL reject_readback: got v=%b %h, want v=1 %h", instr_valid, instr, e.instr);
        end
        tick();
    endtask

    task automatic test_halt_run();
        fetch_req = 1'b1;
        fetch_pc  = 10'd2;
        sb.push_back(exp_for(2));
        tick();
        pop_exp();
        checks++;
        if ({instr_valid, instr} !== {1'b1, e.instr}) begin
            errors++;
            $display("FAIL halt_prebeat: got v=%b %h, want v=1 %h", instr_valid, instr, e.instr);
        end
        halt     = 1'b1;
        run      = 1'b1;
        fetch_pc = 10'd4;
        #1;
        checks++;
        if (fetch_rdy !== 1'b0) begin
            errors++;
            $display("FAIL halt_rdy: got %b, want 0", fetch_rdy);
        end
        tick();
        halt = 1'b0;
        run  = 1'b0;
        #1;
        checks++;
        if ({running, instr_valid, fetch_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL halt_flush: got run=%b v=%b rdy=%b, want 0 0 0",
                     running, instr_valid, fetch_rdy);
        end
        fetch_req = 1'b0;
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL halt_in_load: got run=%b, want 0", running);
        end
    endtask

    task automatic test_byte_addr();
        int    pcs  [5] = '{'h004, 'h006, 'h040, 'h041, 'h00C};
        beat_t exps [5];
        exps[0] = {32'hB000_0001, 1'b0, 1'b0};
        exps[1] = {NOP, 1'b0, 1'b1};
        exps[2] = {NOP, 1'b1, 1'b0};
        exps[3] = {NOP, 1'b1, 1'b1};
        exps[4] = {32'hB000_0003, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            b_prog_we   = 1'b1;
            b_prog_addr = 8'(i);
            b_prog_data = 32'hB000_0000 + 32'(i);
            tick();
        end
        b_prog_we = 1'b0;
        b_run = 1'b1;
        tick();
        b_run = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            if (i > 0) begin
                pop_exp();
                checks++;
                if ({b_instr_valid, b_instr, b_fault_oob, b_fault_misalign} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL byte_pc%0h: got v=%b %h oob=%b mis=%b, want v=1 %h %b %b",
                             pcs[i-1], b_instr_valid, b_instr, b_fault_oob, b_fault_misalign,
                             e.instr, e.oob, e.mis);
                end
            end
            if (i < 5) begin
                b_fetch_req = 1'b1;
                b_fetch_pc  = 8'(pcs[i]);
                sb.push_back(exps[i]);
            end else begin
                b_fetch_req = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        pulse_run();
        fetch_req = 1'b1;
        fetch_pc  = 10'd7;
        sb.push_back(exp_for(7));
        tick();
        fetch_req = 1'b0;
        pop_exp();
        checks++;
        if ({instr_valid, instr} !== {1'b1, e.instr}) begin
            errors++;
            $display("FAIL areset_prebeat: got v=%b %h, want v=1 %h", instr_valid, instr, e.instr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({running, instr_valid, fetch_rdy, fault_oob, fault_misalign, instr} !==
            {5'b0, NOP}) begin
            errors++;
            $display("FAIL areset_immediate: got run=%b v=%b rdy=%b oob=%b mis=%b %h, want 0 %h",
                     running, instr_valid, fetch_rdy, fault_oob, fault_misalign, instr, NOP);
        end
        tick();
        rst_n = 1'b1;
        tick();
        pulse_run();
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                pop_exp();
                checks++;
                if ({instr_valid, instr, fault_oob, fault_misalign} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL areset_readback%0d: got v=%b %h, want v=1 %h",
                             k - 1, instr_valid, instr, e.instr);
                end
            end
            if (k < 9) begin
                fetch_req = 1'b1;
                fetch_pc  = 10'(k);
                sb.push_back(exp_for(k));
            end else begin
                fetch_req = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_faults();
        test_prog_reject();
        test_halt_run();
        test_byte_addr();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
